// File: rtl/trafficlight_monitor.sv
// Passive checker for the 2-bit traffic-light state bus: lamp decode, phase-order/dwell checks, round counting.
// Optional error statistics counter enabled by defining TRAFFICLIGHT_MONITOR_STATS_EN.
module trafficlight_monitor #(
    parameter int RED_TIME    = 4,
    parameter int GREEN_TIME  = 3,
    parameter int YELLOW_TIME = 1,
    parameter int CNT_W       = 4,
    parameter int ROUND_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         light_state,
    input  logic               err_clear,
    output logic               lamp_red,
    output logic               lamp_green,
    output logic               lamp_yellow,
    output logic [ROUND_W-1:0] round_cnt,
    output logic               err_flag,
    output logic [1:0]         err_code,
    output logic               err_pulse,
    output logic [7:0]         err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RED    = 2'd1,
        ST_GREEN  = 2'd2,
        ST_YELLOW = 2'd3
    } light_e;

    localparam logic [CNT_W-1:0] RUN_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] RUN_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] exp_time(input light_e s);
        case (s)
            ST_RED:    exp_time = CNT_W'(RED_TIME);
            ST_GREEN:  exp_time = CNT_W'(GREEN_TIME);
            ST_YELLOW: exp_time = CNT_W'(YELLOW_TIME);
            default:   exp_time = {CNT_W{1'b0}};
        endcase
    endfunction

    light_e           prev_r;
    logic [CNT_W-1:0] run_len_r;
    logic             round_ok_r;

    light_e           cur_s;
    logic             same_s;
    logic             legal_s;
    logic [CNT_W-1:0] exp_s;
    logic [1:0]       code_s;
    logic             err_s;

    // Classify the current sample against the tracked phase.
    always_comb begin
        cur_s   = light_e'(light_state);
        same_s  = (cur_s == prev_r);
        exp_s   = exp_time(prev_r);
        legal_s = 1'b0;
        code_s  = 2'd0;
        if (cur_s == ST_IDLE) begin
            legal_s = 1'b1;
        end else begin
            case (prev_r)
                ST_IDLE:   legal_s = (cur_s == ST_RED);
                ST_RED:    legal_s = (cur_s == ST_GREEN);
                ST_GREEN:  legal_s = (cur_s == ST_YELLOW);
                ST_YELLOW: legal_s = (cur_s == ST_RED);
                default:   legal_s = 1'b0;
            endcase
        end
        if (!same_s) begin
            if (!legal_s) begin
                code_s = 2'd1;
            end else if ((cur_s != ST_IDLE) && (prev_r != ST_IDLE) && (run_len_r < exp_s)) begin
                code_s = 2'd2;
            end else begin
                code_s = 2'd0;
            end
        end else if ((prev_r != ST_IDLE) && (run_len_r == exp_s)) begin
            // run_len saturates above any legal Exp, so overstay fires only once per phase
            code_s = 2'd3;
        end else begin
            code_s = 2'd0;
        end
        err_s = (code_s != 2'd0);
    end

    // Lamp decode and phase/run-length tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            lamp_red    <= 1'b0;
            lamp_green  <= 1'b0;
            lamp_yellow <= 1'b0;
            prev_r      <= ST_IDLE;
            run_len_r   <= {CNT_W{1'b0}};
        end else begin
            lamp_red    <= (cur_s == ST_RED);
            lamp_green  <= (cur_s == ST_GREEN);
            lamp_yellow <= (cur_s == ST_YELLOW);
            if (same_s) begin
                if (run_len_r != RUN_MAX) begin
                    run_len_r <= run_len_r + RUN_ONE;
                end
            end else begin
                prev_r    <= cur_s;
                run_len_r <= RUN_ONE;
            end
        end
    end

    // Error reporting: first code is held until cleared; a coincident new error beats err_clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse <= 1'b0;
            err_flag  <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            err_pulse <= err_s;
            if (err_s) begin
                err_flag <= 1'b1;
                if (!err_flag || err_clear) begin
                    err_code <= code_s;
                end
            end else if (err_clear) begin
                err_flag <= 1'b0;
                err_code <= 2'd0;
            end
        end
    end

    // Round qualification and counting of clean YELLOW->RED completions.
    always_ff @(posedge clk) begin
        if (rst) begin
            round_ok_r <= 1'b0;
            round_cnt  <= {ROUND_W{1'b0}};
        end else if (err_s) begin
            round_ok_r <= 1'b0;
        end else begin
            if ((prev_r == ST_YELLOW) && (cur_s == ST_RED) && round_ok_r) begin
                round_cnt <= round_cnt + {{(ROUND_W-1){1'b0}}, 1'b1};
            end
            if (!same_s && (cur_s == ST_IDLE)) begin
                round_ok_r <= 1'b0;
            end else if (!same_s && (cur_s == ST_RED)) begin
                round_ok_r <= 1'b1;
            end
        end
    end

`ifdef TRAFFICLIGHT_MONITOR_STATS_EN
    logic [7:0] err_cnt_r;

    // Saturating error statistics, untouched by err_clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= 8'd0;
        end else if (err_s && (err_cnt_r != 8'hFF)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end
    end

    assign err_cnt = err_cnt_r;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_trafficlight_monitor.sv
// Self-checking bench for trafficlight_monitor: directed scenarios plus randomized bus traffic
// compared against a sample-history reference model.
module tb_trafficlight_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] light_state = 2'd0;
    logic       err_clear = 1'b0;
    logic       lamp_red, lamp_green, lamp_yellow;
    logic [7:0] round_cnt;
    logic       err_flag;
    logic [1:0] err_code;
    logic       err_pulse;
    logic [7:0] err_cnt;

    int tests = 0;
    int fails = 0;

    trafficlight_monitor dut (
        .clk(clk), .rst(rst), .light_state(light_state), .err_clear(err_clear),
        .lamp_red(lamp_red), .lamp_green(lamp_green), .lamp_yellow(lamp_yellow),
        .round_cnt(round_cnt), .err_flag(err_flag), .err_code(err_code),
        .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: expected dwell per state, history of samples since reset.
    int exp_t [4] = '{0, 4, 3, 1};
    int hist [$];
    int m_round = 0;
    int m_flag = 0;
    int m_code = 0;
    int m_pulse = 0;
    int m_rok = 0;
    int m_ecnt = 0;
    int m_lr = 0, m_lg = 0, m_ly = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model(input int s, input int c, input int r);
        int p, rl, code, legal, err;
        if (r != 0) begin
            hist.delete();
            m_round = 0; m_flag = 0; m_code = 0; m_pulse = 0;
            m_rok = 0; m_ecnt = 0; m_lr = 0; m_lg = 0; m_ly = 0;
        end else begin
            p  = (hist.size() == 0) ? 0 : hist[hist.size()-1];
            rl = 0;
            for (int i = hist.size() - 1; i >= 0; i--) begin
                if (hist[i] != p) break;
                rl++;
            end
            if (rl > 15) rl = 15;
            code = 0;
            if (s != p) begin
                legal = (s == 0) || (p == 0 && s == 1) || (p != 0 && s == (p % 3) + 1);
                if (legal == 0) code = 1;
                else if (s != 0 && p != 0 && rl < exp_t[p]) code = 2;
            end else if (p != 0 && rl == exp_t[p]) begin
                code = 3;
            end
            err = (code != 0);
            m_pulse = err;
            if (err != 0) begin
                if (m_flag == 0 || c != 0) m_code = code;
                m_flag = 1;
                m_rok = 0;
                if (m_ecnt < 255) m_ecnt++;
            end else begin
                if (c != 0) begin m_flag = 0; m_code = 0; end
                if (p == 3 && s == 1 && m_rok != 0) m_round = (m_round + 1) % 256;
                if (s != p && s == 0) m_rok = 0;
                else if (s != p && s == 1) m_rok = 1;
            end
            m_lr = (s == 1); m_lg = (s == 2); m_ly = (s == 3);
            hist.push_back(s);
            if (hist.size() > 20) void'(hist.pop_front());
        end
    endtask

    task automatic step(input int s, input int c, input int r);
        @(negedge clk);
        light_state = 2'(s);
        err_clear   = c[0];
        rst         = r[0];
        @(posedge clk);
        model(s, c, r);
        #1;
        chk("lamp_red", int'(lamp_red), m_lr);
        chk("lamp_green", int'(lamp_green), m_lg);
        chk("lamp_yellow", int'(lamp_yellow), m_ly);
        chk("round_cnt", int'(round_cnt), m_round);
        chk("err_flag", int'(err_flag), m_flag);
        chk("err_code", int'(err_code), m_code);
        chk("err_pulse", int'(err_pulse), m_pulse);
`ifdef TRAFFICLIGHT_MONITOR_STATS_EN
        chk("err_cnt", int'(err_cnt), m_ecnt);
`else
        chk("err_cnt", int'(err_cnt), 0);
`endif
    endtask

    task automatic steps(input int s, input int n);
        for (int k = 0; k < n; k++) step(s, 0, 0);
    endtask

    initial begin
        int cur, nxt, len;

        // Clean round
        step(0, 0, 1);
        chk("reset_outputs", int'({lamp_red, lamp_green, lamp_yellow, err_flag, err_pulse, err_code}), 0);
        chk("reset_round", int'(round_cnt), 0);
        steps(0, 2);
        step(1, 0, 0);
        chk("clean_lamp_red_rise", int'(lamp_red), 1);
        steps(1, 3);
        steps(2, 3);
        step(3, 0, 0);
        chk("clean_round_before", int'(round_cnt), 0);
        step(1, 0, 0);
        chk("clean_round_after", int'(round_cnt), 1);
        chk("clean_no_err", int'(err_flag), 0);

        // Short dwell
        step(0, 0, 1);
        step(0, 0, 0);
        steps(1, 3);
        step(2, 0, 0);
        chk("short_pulse", int'(err_pulse), 1);
        chk("short_code", int'(err_code), 2);
        chk("short_flag", int'(err_flag), 1);
        step(2, 0, 0);
        chk("short_pulse_drop", int'(err_pulse), 0);
        steps(2, 1);
        step(3, 0, 0);
        step(1, 0, 0);
        chk("short_no_round", int'(round_cnt), 0);

        // Overstay
        step(0, 0, 1);
        step(0, 0, 0);
        steps(1, 4);
        steps(2, 3);
        chk("over_quiet", int'(err_pulse), 0);
        step(2, 0, 0);
        chk("over_pulse", int'(err_pulse), 1);
        chk("over_code", int'(err_code), 3);
        step(2, 0, 0);
        chk("over_single", int'(err_pulse), 0);

        // Illegal order, held code, clear, clear with coincident error
        step(0, 0, 1);
        step(0, 0, 0);
        steps(1, 4);
        step(3, 0, 0);
        chk("illegal_code", int'(err_code), 1);
        step(1, 0, 0);
        step(2, 0, 0);
        chk("held_pulse", int'(err_pulse), 1);
        chk("held_code", int'(err_code), 1);
        step(2, 1, 0);
        chk("clear_flag", int'(err_flag), 0);
        chk("clear_code", int'(err_code), 0);
        step(1, 0, 0);
        chk("reillegal_code", int'(err_code), 1);
        step(2, 1, 0);
        chk("clr_err_flag", int'(err_flag), 1);
        chk("clr_err_code", int'(err_code), 2);

        // Abort to IDLE and reset mid-RED
        step(0, 0, 1);
        step(0, 0, 0);
        steps(1, 4);
        step(2, 0, 0);
        step(0, 0, 0);
        chk("abort_flag", int'(err_flag), 0);
        chk("abort_pulse", int'(err_pulse), 0);
        chk("abort_round", int'(round_cnt), 0);
        steps(1, 2);
        step(1, 0, 1);
        chk("midred_rst", int'({lamp_red, lamp_green, lamp_yellow, err_flag, err_pulse, err_code, round_cnt}), 0);

`ifdef TRAFFICLIGHT_MONITOR_STATS_EN
        // Error statistics
        step(0, 0, 0);
        step(2, 0, 0);
        step(1, 0, 0);
        step(2, 0, 0);
        chk("stats_three", int'(err_cnt), 3);
        step(2, 1, 0);
        chk("stats_clear_keep", int'(err_cnt), 3);
        step(0, 0, 1);
        chk("stats_rst", int'(err_cnt), 0);
`endif

        // Randomized traffic, mostly legal with perturbed dwell times
        step(0, 0, 1);
        cur = 0;
        for (int ph = 0; ph < 300; ph++) begin
            if ($urandom % 8 == 0) nxt = int'($urandom % 4);
            else if (cur == 0) nxt = 1;
            else if ($urandom % 10 == 0) nxt = 0;
            else nxt = (cur % 3) + 1;
            len = (nxt == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, exp_t[nxt] + 2));
            for (int k = 0; k < len; k++) begin
                step(nxt, ($urandom % 20 == 0) ? 1 : 0, ($urandom % 200 == 0) ? 1 : 0);
            end
            cur = nxt;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/trafficlight_monitor.md
Name: trafficlight_monitor

Overview:
- Passive checker on the receiving end of the 2-bit traffic-light state bus (IDLE=0, RED=1, GREEN=2, YELLOW=3).
- Samples the bus every clock and drives one-hot lamp outputs.
- Checks phase order and dwell times against parameters, and counts clean R->G->Y rounds.
- Sits beside the light controller; drives lamp pins and a sticky error report to the host.

Parameters:
- RED_TIME, 4, expected consecutive RED samples per phase (1..2^CNT_W-2)
- GREEN_TIME, 3, expected consecutive GREEN samples per phase
- YELLOW_TIME, 1, expected consecutive YELLOW samples per phase
- CNT_W, 4, width of dwell counter
- ROUND_W, 8, width of round counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- light_state  in  2  observed controller state
- err_clear  in  1  clears err_flag/err_code
- lamp_red  out  1  registered decode of light_state==RED
- lamp_green  out  1  registered decode of light_state==GREEN
- lamp_yellow  out  1  registered decode of light_state==YELLOW
- round_cnt  out  ROUND_W  clean rounds completed, wraps
- err_flag  out  1  sticky error
- err_code  out  2  first error: 0 none, 1 illegal order, 2 short dwell, 3 overstay
- err_pulse  out  1  one-cycle strobe per detected error
- err_cnt  out  8  error count (optional feature)

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0, prev=IDLE, run_len=0, round_ok=0.
- Every edge: lamps <= one-hot decode of light_state (1-cycle latency); IDLE gives all lamps off.
- Tracking:
  - if light_state==prev: run_len <= run_len+1, saturating at 2^CNT_W-1
  - else: prev <= light_state, run_len <= 1
- "Exp(s)" is RED_TIME, GREEN_TIME or YELLOW_TIME for s = RED, GREEN, YELLOW.
- Checks are evaluated on the current sample against prev/run_len. Results register at that edge and are visible the next cycle.
  - Legal transitions: IDLE->RED, RED->GREEN, GREEN->YELLOW, YELLOW->RED, and any->IDLE. Any other change (e.g. IDLE->GREEN, RED->YELLOW) is code 1.
  - Short dwell: transition out of RED/GREEN/YELLOW to a non-IDLE state with run_len < Exp(prev) is code 2.
  - Overstay: light_state==prev in RED/GREEN/YELLOW with run_len == Exp(prev), i.e. the Exp+1-th sample, is code 3. It fires once; later samples of the same phase do not re-fire.
  - Transition to IDLE is never a dwell error (abort). It clears round_ok.
  - Illegal order takes priority over short dwell in the same sample.
- Error reporting:
  - On any error: err_pulse=1 for one cycle; err_flag <= 1; round_ok <= 0.
  - err_code is loaded only if err_flag is 0, so the first error is held.
- err_clear: err_flag <= 0, err_code <= 0. A simultaneous new error wins: flag=1 and the new code is loaded.
- Rounds:
  - Any legal transition into RED sets round_ok=1, unless that sample errors.
  - On a YELLOW->RED sample with round_ok=1 and no error this sample: round_cnt <= round_cnt+1, modulo 2^ROUND_W.
  - The IDLE->RED start does not count.
- rst mid-round: everything returns to reset values. The next RED is treated as coming from IDLE.

Optional Feature:
- Macro TRAFFICLIGHT_MONITOR_STATS_EN.
- Defined: err_cnt increments on every err_pulse, saturating at 255. It is cleared only by rst, not by err_clear.
- Undefined: err_cnt is tied to 0 and no counter logic exists.

Test Plan:
- Clean round: rst, then IDLE x2, RED x4, GREEN x3, YELLOW x1, RED.
  - err_flag=0 throughout.
  - round_cnt 0->1 one cycle after the second RED sample.
  - lamp_red rises one cycle after the first RED sample.
- Short dwell: RED x3 then GREEN -> err_pulse one cycle, err_code=2, err_flag=1. The completing YELLOW->RED does not bump round_cnt.
- Overstay: GREEN held 5 samples -> single err_pulse on the 4th GREEN sample, err_code=3.
- Illegal order: RED x4 then YELLOW -> err_code=1.
  - A following short-dwell error leaves the code at 1.
  - err_clear -> flag and code return to 0.
  - err_clear coincident with a new error -> flag=1 with the new code.
- Abort: GREEN x1 then IDLE -> no error and round_cnt unchanged. rst asserted mid-RED -> all outputs 0 the next cycle.
- Macro defined: three errors -> err_cnt=3; err_clear leaves err_cnt at 3; rst -> 0.
